spi_cmd_master: RTL and testbench

- SPI mode-0 initiator that drives the safety board's command/response protocol from the host side.
- Sits in the host-bridge FPGA and in the board-level bench as the stimulus end of the link. It accepts one command request, serialises {cmd, index, data} as three 8-bit MSB-first words under a single chip-select assertion, and returns the word received during the third word.
- Rejects opcodes outside the defined command set without touching the bus.

---
 rtl/spi_cmd_master.sv | 166 ++++++++++++++++
 tb/tb_spi_cmd_master.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_master.sv
// SPI mode-0 command initiator: sends {cmd, index, payload} as 24 MSB-first bits
// under one chip-select assertion and returns the byte received during the third word.
module spi_cmd_master #(
  parameter int CLK_DIV  = 2,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_cmd,
  input  logic [7:0] req_index,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       busy,
  output logic       spi_sclk,
  output logic       spi_cs_n,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam int MAX_AB  = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int MAX_CD  = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
  localparam int CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, DECODE, SETUP, SHIFT, HOLD, RESP, GAP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    bit_q, bit_d;
  logic [23:0]   tx_q, tx_d;
  logic [7:0]    rx_q, rx_d;
  logic          sclk_d, cs_n_d, mosi_d, rsp_valid_d, rsp_err_d;
  logic [7:0]    rdata_d;

  // Defined set: 0x00-0x04 reads, 0x81-0x84 writes.
  function automatic logic is_valid_op(input logic [7:0] op);
    return (op[6:3] == 4'h0) && (op[2:0] <= 3'd4) && !(op[7] && (op[2:0] == 3'd0));
  endfunction

  always_comb begin
    // NOTE: every signal gets its hold value first so no branch can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    sclk_d      = spi_sclk;
    cs_n_d      = spi_cs_n;
    mosi_d      = spi_mosi;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rdata_d     = rsp_rdata;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          tx_d    = {req_cmd, req_index, req_cmd[7] ? req_wdata : 8'h00};
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (is_valid_op(tx_q[23:16])) begin
          state_d = SETUP;
          cnt_d   = '0;
          cs_n_d  = 1'b0;
          mosi_d  = tx_q[23];
        end else begin
          // Rejected opcodes answer immediately and never touch the bus.
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rdata_d     = 8'h00;
        end
      end
      SETUP: begin
        if (cnt_q == CW'(CS_SETUP - 1)) begin
          state_d = SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        if (cnt_q == CW'(CLK_DIV - 1)) begin
          cnt_d = '0;
          if (!spi_sclk) begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[6:0], spi_miso};
          end else begin
            sclk_d = 1'b0;
            if (bit_q == 5'd23) begin
              state_d = HOLD;
            end else begin
              bit_d  = bit_q + 5'd1;
              tx_d   = {tx_q[22:0], 1'b0};
              mosi_d = tx_q[22];
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == CW'(CS_HOLD - 1)) begin
          state_d     = RESP;
          cnt_d       = '0;
          cs_n_d      = 1'b1;
          rsp_valid_d = 1'b1;
          rdata_d     = rx_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        mosi_d  = 1'b0;
        state_d = (CS_IDLE > 1) ? GAP : IDLE;
      end
      GAP: begin
        if (cnt_q == CW'(CS_IDLE - 2)) state_d = IDLE;
        else                           cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // req_ready/busy are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      spi_sclk  <= 1'b0;
      spi_cs_n  <= 1'b1;
      spi_mosi  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 8'h00;
      busy      <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      spi_sclk  <= sclk_d;
      spi_cs_n  <= cs_n_d;
      spi_mosi  <= mosi_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rdata_d;
      busy      <= (state_d != IDLE);
      req_ready <= (state_d == IDLE);
    end
  end

endmodule

// File: tb/tb_spi_cmd_master.sv
// Scoreboard bench for spi_cmd_master: two instances (default timing and all-ones timing)
// driven with directed and random commands against a transaction-level model.
module tb_spi_cmd_master;

  typedef struct {
    logic [23:0] mosi;
    logic [7:0]  rdata;
    logic        err;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      rst, req_valid, req_ready, rsp_valid, rsp_err, busy, sclk, cs_n, mosi, miso;
  logic [1:0][7:0] req_cmd, req_index, req_wdata, rsp_rdata;

  int total = 0;
  int bad   = 0;

  exp_t        exp_q [2][$];
  logic [23:0] slv_q [2][$];

  int          ncyc = 0;
  bit          pend     [2];
  int          acc_t    [2];
  int          last_acc [2];
  int          last_rsp [2];
  int          rises    [2];
  int          cs_lo    [2];
  int          rdy_hi   [2];
  int          hi_run   [2];
  int          idle_tgl [2];
  int          slv_n    [2];
  logic [23:0] cap      [2];
  logic [23:0] slv_w    [2];
  logic        prev_sclk[2];
  logic        prev_cs  [2];
  logic [7:0]  last_rdata [2];

  spi_cmd_master #(.CLK_DIV(2), .CS_SETUP(2), .CS_HOLD(2), .CS_IDLE(2)) u0 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_cmd(req_cmd[0]), .req_index(req_index[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .busy(busy[0]),
    .spi_sclk(sclk[0]), .spi_cs_n(cs_n[0]), .spi_mosi(mosi[0]), .spi_miso(miso[0])
  );

  spi_cmd_master #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .CS_IDLE(1)) u1 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_cmd(req_cmd[1]), .req_index(req_index[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .busy(busy[1]),
    .spi_sclk(sclk[1]), .spi_cs_n(cs_n[1]), .spi_mosi(mosi[1]), .spi_miso(miso[1])
  );

  function automatic int div_of(input int i);  return (i == 0) ? 2 : 1; endfunction
  function automatic int set_of(input int i);  return (i == 0) ? 2 : 1; endfunction
  function automatic int hold_of(input int i); return (i == 0) ? 2 : 1; endfunction
  function automatic int idle_of(input int i); return (i == 0) ? 2 : 1; endfunction
  function automatic int lat_of(input int i);
    return 1 + set_of(i) + 48 * div_of(i) + hold_of(i);
  endfunction

  function automatic bit op_ok(input logic [7:0] c);
    return c inside {8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h81, 8'h82, 8'h83, 8'h84};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave and monitor for one instance, evaluated on every falling clk edge.
  task automatic mon_step(input int i);
    exp_t e;
    if (!cs_n[i] && prev_cs[i]) begin
      slv_w[i] = (slv_q[i].size() != 0) ? slv_q[i].pop_front() : 24'h0;
      slv_n[i] = 1;
      miso[i]  = slv_w[i][23];
    end else if (!cs_n[i] && prev_sclk[i] && !sclk[i] && slv_n[i] < 24) begin
      miso[i]  = slv_w[i][23 - slv_n[i]];
      slv_n[i] = slv_n[i] + 1;
    end

    if (rst[i]) begin
      pend[i] = 1'b0;
    end else begin
      if (cs_n[i] && sclk[i]) idle_tgl[i]++;
      if (rsp_valid[i]) begin
        if (exp_q[i].size() == 0 || !pend[i]) begin
          check($sformatf("u%0d_unexpected_rsp", i), 32'd1, 32'd0);
        end else begin
          e = exp_q[i].pop_front();
          check($sformatf("u%0d_rdata", i), 32'(rsp_rdata[i]), 32'(e.rdata));
          check($sformatf("u%0d_err", i), 32'(rsp_err[i]), 32'(e.err));
          check($sformatf("u%0d_latency", i), ncyc - acc_t[i], e.lat);
          if (e.err) begin
            check($sformatf("u%0d_err_sclk_rises", i), rises[i], 0);
            check($sformatf("u%0d_err_cs_low", i), cs_lo[i], 0);
          end else begin
            check($sformatf("u%0d_mosi_stream", i), 32'(cap[i]), 32'(e.mosi));
            check($sformatf("u%0d_sclk_rises", i), rises[i], 24);
            check($sformatf("u%0d_cs_low_cycles", i), cs_lo[i], e.lat - 1);
            check($sformatf("u%0d_ready_while_busy", i), rdy_hi[i], 0);
          end
          last_rdata[i] = e.rdata;
        end
        pend[i]     = 1'b0;
        last_rsp[i] = ncyc;
      end else if (pend[i]) begin
        if (req_ready[i]) rdy_hi[i]++;
        if (!cs_n[i])     cs_lo[i]++;
        if (sclk[i] && !prev_sclk[i]) begin
          rises[i]++;
          cap[i] = {cap[i][22:0], mosi[i]};
        end
      end
      if (!cs_n[i] && prev_cs[i])
        check($sformatf("u%0d_cs_high_spacing", i), 32'(hi_run[i] >= idle_of(i)), 32'd1);
      hi_run[i] = cs_n[i] ? hi_run[i] + 1 : 0;
      if (req_valid[i] && req_ready[i]) begin
        pend[i]     = 1'b1;
        acc_t[i]    = ncyc + 1;
        last_acc[i] = ncyc;
        rises[i]    = 0;
        cs_lo[i]    = 0;
        rdy_hi[i]   = 0;
        cap[i]      = '0;
      end
    end
    prev_cs[i]   = cs_n[i];
    prev_sclk[i] = sclk[i];
  endtask

  initial begin
    miso = 2'b00;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; acc_t[i] = 0; last_acc[i] = 0; last_rsp[i] = 0; rises[i] = 0;
      cs_lo[i] = 0; rdy_hi[i] = 0; hi_run[i] = 0; idle_tgl[i] = 0; slv_n[i] = 24;
      cap[i] = '0; slv_w[i] = '0; prev_sclk[i] = 1'b0; prev_cs[i] = 1'b1; last_rdata[i] = 8'h00;
    end
    forever begin
      @(negedge clk);
      ncyc++;
      for (int i = 0; i < 2; i++) mon_step(i);
    end
  end

  task automatic send(input int i, input logic [7:0] c, input logic [7:0] x,
                      input logic [7:0] w, input logic [7:0] rb, input bit keep);
    exp_t e;
    int   t;
    req_cmd[i]   = c;
    req_index[i] = x;
    req_wdata[i] = w;
    req_valid[i] = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!req_ready[i] && t < 500);
    check($sformatf("u%0d_accept", i), 32'(req_ready[i]), 32'd1);
    e.err   = !op_ok(c);
    e.mosi  = {c, x, c[7] ? w : 8'h00};
    e.rdata = e.err ? 8'h00 : rb;
    e.lat   = e.err ? 1 : lat_of(i);
    exp_q[i].push_back(e);
    if (!e.err) slv_q[i].push_back({8'($urandom), 8'($urandom), rb});
    @(posedge clk);
    #1;
    if (!keep) req_valid[i] = 1'b0;
  endtask

  task automatic wait_done(input int i);
    int t;
    t = 0;
    while (exp_q[i].size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("u%0d_drain", i), exp_q[i].size(), 0);
    @(negedge clk);
    check($sformatf("u%0d_rdata_hold", i), 32'(rsp_rdata[i]), 32'(last_rdata[i]));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] ops [9];
    logic [7:0] c, w;
    int t;
    ops = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h81, 8'h82, 8'h83, 8'h84};
    rst = 2'b11; req_valid = 2'b00; req_cmd = '0; req_index = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 2'b00;
    @(negedge clk);
    for (int i = 0; i < 2; i++)
      check($sformatf("u%0d_reset_state", i),
            32'({req_ready[i], busy[i], cs_n[i], sclk[i], mosi[i], rsp_valid[i], rsp_err[i], rsp_rdata[i]}),
            32'({7'b1010000, 8'h00}));
    @(posedge clk);
    #1;

    // Read status, write contactor with echo, invalid opcode.
    send(0, 8'h03, 8'h00, 8'h5A, 8'hC0, 1'b0);
    wait_done(0);
    send(0, 8'h81, 8'h05, 8'h02, 8'h02, 1'b0);
    wait_done(0);
    send(0, 8'h55, 8'h11, 8'h22, 8'h00, 1'b0);
    wait_done(0);

    // Back-to-back with req_valid held: second accepted on the first IDLE cycle.
    send(0, 8'h02, 8'h03, 8'h00, 8'h9E, 1'b1);
    send(0, 8'h84, 8'h01, 8'h77, 8'h77, 1'b0);
    check("u0_b2b_accept_gap", last_acc[0] - last_rsp[0], idle_of(0));
    wait_done(0);

    // Reset in the middle of bit 10, then a normal request.
    send(0, 8'h01, 8'h07, 8'h00, 8'h3C, 1'b0);
    t = 0;
    while (!(rises[0] == 10 && !sclk[0]) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("u0_reach_bit10", rises[0], 10);
    @(posedge clk);
    #1;
    rst[0] = 1'b1;
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    if (exp_q[0].size() != 0) void'(exp_q[0].pop_front());
    @(negedge clk);
    check("u0_after_reset",
          32'({cs_n[0], sclk[0], mosi[0], busy[0], req_ready[0], rsp_valid[0]}), 32'(6'b100010));
    @(posedge clk);
    #1;
    send(0, 8'h04, 8'h02, 8'h00, 8'h5A, 1'b0);
    wait_done(0);

    // Fast timing instance: read feedback returning 0xA5.
    send(1, 8'h02, 8'h01, 8'h00, 8'hA5, 1'b0);
    wait_done(1);

    // Random commands per instance, sometimes back-to-back.
    for (int i = 0; i < 2; i++) begin
      for (int n = 0; n < 8; n++) begin
        c = ($urandom_range(0, 3) == 0) ? 8'($urandom) : ops[$urandom_range(0, 8)];
        w = 8'($urandom);
        send(i, c, 8'($urandom), w, c[7] ? w : 8'($urandom), (n < 7) ? 1'($urandom_range(0, 1)) : 1'b0);
      end
      wait_done(i);
      check($sformatf("u%0d_sclk_while_cs_high", i), idle_tgl[i], 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
